// File: rtl/vector_alu_pipe.sv
// Vector ALU stage: lane-wise ADD/SUB, XOR/XOR3, byte rotate and GF(2^8) byte multiply over LANES lanes.
// Latency: 1 cycle for ADD/SUB/XOR/XOR3/ROTL/illegal, 8 cycles for GFMUL (iterative shift-and-add).
// Backpressure: single output slot; in_ready drops while GFMUL iterates or while an untaken result is held.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/op/src_a/src_b/src_c/index issue side;
//        out_valid/out_ready/result/err writeback side.
module vector_alu_pipe #(
    parameter int LANES  = 4,
    parameter int LANE_W = 32,
    parameter int IDX_W  = $clog2(LANE_W / 8)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [3:0]                op,
    input  logic [LANES*LANE_W-1:0]   src_a,
    input  logic [LANES*LANE_W-1:0]   src_b,
    input  logic [LANES*LANE_W-1:0]   src_c,
    input  logic [IDX_W-1:0]          index,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*LANE_W-1:0]   result,
    output logic                      err
);

    localparam int W  = LANES * LANE_W;
    localparam int NB = W / 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0010;
    localparam logic [3:0] OP_XOR3  = 4'b0011;
    localparam logic [3:0] OP_ROTL  = 4'b0100;
    localparam logic [3:0] OP_GFMUL = 4'b0101;

    typedef enum logic {IDLE, MUL} state_t;

    state_t         state;
    logic [2:0]     cnt;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   a_nx;
    logic [W-1:0]   acc_nx;
    logic [W-1:0]   alu_res;
    logic           alu_err;
    logic [2*LANE_W-1:0] rot;
    logic           accept;

    // Slot may be refilled on the same edge it is drained.
    assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // One shift-and-add step per byte: bit cnt of b selects the current a,
    // then a is multiplied by x (xtime) for the next bit.
    always_comb begin
        a_nx   = '0;
        acc_nx = '0;
        for (int k = 0; k < NB; k++) begin
            acc_nx[k*8 +: 8] = acc_q[k*8 +: 8] ^ (b_q[k*8 + int'(cnt)] ? a_q[k*8 +: 8] : 8'h00);
            a_nx[k*8 +: 8]   = {a_q[k*8 +: 7], 1'b0} ^ (a_q[k*8 + 7] ? 8'h1B : 8'h00);
        end
    end

    // Single-cycle datapath.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        rot     = '0;
        case (op)
            OP_ADD: begin
                for (int i = 0; i < LANES; i++)
                    alu_res[i*LANE_W +: LANE_W] = src_a[i*LANE_W +: LANE_W] + src_b[i*LANE_W +: LANE_W];
            end
            OP_SUB: begin
                for (int i = 0; i < LANES; i++)
                    alu_res[i*LANE_W +: LANE_W] = src_a[i*LANE_W +: LANE_W] - src_b[i*LANE_W +: LANE_W];
            end
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_XOR3: alu_res = src_a ^ src_b ^ src_c;
            OP_ROTL: begin
                // Rotate by shifting a doubled copy; the upper half is the rotated lane.
                for (int i = 0; i < LANES; i++) begin
                    rot = {src_a[i*LANE_W +: LANE_W], src_a[i*LANE_W +: LANE_W]} << (int'(index) * 8);
                    alu_res[i*LANE_W +: LANE_W] = rot[2*LANE_W-1 -: LANE_W];
                end
            end
            OP_GFMUL: alu_res = '0;
            default:  alu_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (op == OP_GFMUL) begin
                            a_q   <= src_a;
                            b_q   <= src_b;
                            acc_q <= '0;
                            cnt   <= '0;
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            err       <= alu_err;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    a_q   <= a_nx;
                    acc_q <= acc_nx;
                    cnt   <= cnt + 3'd1;
                    // MUL only starts with a free slot, so nothing is overwritten here.
                    if (cnt == 3'd7) begin
                        result    <= acc_nx;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_alu_pipe.sv
module tb_vector_alu_pipe;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [127:0] src_a, src_b, src_c;
    logic [1:0]   index;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] result;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    vector_alu_pipe #(.LANES(4), .LANE_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .src_c     (src_c),
        .index     (index),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, take the accept edge, drop in_valid.
    task automatic issue(input logic [3:0] o, input logic [127:0] a, input logic [127:0] b,
                         input logic [127:0] c, input logic [1:0] idx);
        op = o; src_a = a; src_b = b; src_c = c; index = idx;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; src_a = '0; src_b = '0; src_c = '0; index = '0;

        // Reset state
        #1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // T1 ADD: per-lane wrap, no carry into lane2
        issue(4'h0, 128'h00000000_00000007_FFFFFFFF_00000008,
                    128'h00000000_00000000_00000001_00000005, '0, 2'd0);
        check("add_valid", out_valid, 1);
        check("add_result", result, 128'h00000000_00000007_00000000_0000000D);
        check("add_err", err, 0);

        // T2 SUB with borrow confined to lane
        issue(4'h1, 128'h00000000_00000000_00000003_0000000A,
                    128'h00000000_00000000_0000000A_00000003, '0, 2'd0);
        check("sub_result", result, 128'h00000000_00000000_FFFFFFF9_00000007);

        issue(4'h2, 128'h0_0_0_FF00FF00, 128'h0_0_0_0F0F0F0F, '0, 2'd0);
        check("xor_result", result, 128'h00000000_00000000_00000000_F00FF00F);

        issue(4'h3, 128'h0A, 128'h03, 128'h25423513, 2'd0);
        check("xor3_result", result, 128'h00000000_00000000_00000000_2542351A);

        // T3 ROTL
        issue(4'h4, 128'h00000000_00000000_11223344_1BC492BB, '0, '0, 2'd1);
        check("rotl1", result, 128'h00000000_00000000_22334411_C492BB1B);
        issue(4'h4, 128'h1BC492BB, '0, '0, 2'd3);
        check("rotl3", result, 128'h00000000_00000000_00000000_BB1BC492);
        issue(4'h4, 128'h1BC492BB, '0, '0, 2'd0);
        check("rotl0", result, 128'h00000000_00000000_00000000_1BC492BB);

        // T4 GFMUL: 57*83=C1, 57*13=FE, AB*01=AB, CD*00=00
        issue(4'h5, 128'hCDAB5757, 128'h00011383, '0, 2'd0);
        check("gf_valid_e0", out_valid, 0);
        check("gf_ready_e0", in_ready, 0);
        for (int i = 1; i < 8; i++) begin
            tick();
            check($sformatf("gf_valid_e%0d", i), out_valid, 0);
            check($sformatf("gf_ready_e%0d", i), in_ready, 0);
        end
        tick();
        check("gf_valid_e8", out_valid, 1);
        check("gf_result", result, 128'h00000000_00000000_00000000_00ABFEC1);
        check("gf_err", err, 0);
        tick();
        check("gf_drained", out_valid, 0);

        // T5 backpressure then a back-to-back stream
        out_ready = 1'b0;
        issue(4'h0, 128'h1, 128'h2, '0, 2'd0);
        op = 4'h0; src_a = 128'h50; src_b = 128'h50; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_in_ready%0d", i), in_ready, 0);
            tick();
            check($sformatf("bp_valid%0d", i), out_valid, 1);
            check($sformatf("bp_result%0d", i), result, 128'h3);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_a = 128'(i + 1); src_b = 128'h64;
            #1;
            check($sformatf("st_in_ready%0d", i), in_ready, 1);
            tick();
            check($sformatf("st_valid%0d", i), out_valid, 1);
            check($sformatf("st_result%0d", i), result, 128'(101 + i));
        end
        in_valid = 1'b0;
        tick();
        check("st_drained", out_valid, 0);

        // T6 reset during MUL abandons the multiply
        issue(4'h5, 128'h57, 128'h83, '0, 2'd0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("abandon_valid%0d", i), out_valid, 0);
        end

        // Illegal op, then a legal op clears err
        issue(4'hF, 128'hDEADBEEF, 128'h1, '0, 2'd0);
        check("ill_valid", out_valid, 1);
        check("ill_err", err, 1);
        check("ill_result", result, 0);
        issue(4'h6, 128'h5, 128'h5, '0, 2'd0);
        check("ill6_err", err, 1);
        issue(4'h0, 128'h5, 128'h6, '0, 2'd0);
        check("legal_err", err, 0);
        check("legal_result", result, 128'hB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
